pipeline_foreground_capture_writer: RTL

// Write-side counterpart of the foreground scaler. Takes the incoming foreground video

---
 rtl/pipeline_foreground_capture_writer_if.sv | 25 ++
 rtl/pipeline_foreground_capture_writer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipeline_foreground_capture_writer_if.sv
// Framebuffer write-request channel: valid/ready with word address and pixel.
// The writer drives the master side; the memory arbiter is the slave.
interface pipeline_foreground_capture_writer_if #(
  parameter int ADDR_WIDTH  = 20,
  parameter int COLOR_WIDTH = 16
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [COLOR_WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/pipeline_foreground_capture_writer.sv
// Foreground capture writer: decimates the incoming stream by 2^scale and
// queues framebuffer writes through a small FIFO toward the arbiter.
module pipeline_foreground_capture_writer #(
  parameter int RESOLUTION_X = 800,
  parameter int RESOLUTION_Y = 600,
  parameter int PRECISION    = 11,
  parameter int COLOR_WIDTH  = 16,
  parameter int ADDR_WIDTH   = 20,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             ctrl_foreground_scale,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [COLOR_WIDTH-1:0] in_pixel,
  pipeline_foreground_capture_writer_if.master wr,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + COLOR_WIDTH;
  localparam logic [PRECISION-1:0] X_LAST =
    PRECISION'(RESOLUTION_X - 1);
  localparam logic [PRECISION-1:0] Y_LAST =
    PRECISION'(RESOLUTION_Y - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP =
    ADDR_WIDTH'(RESOLUTION_X);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t state, state_nx;

  logic [PRECISION-1:0]  x, y, x_nx, y_nx;
  logic [PRECISION-1:0]  cur_x, cur_y, mask;
  logic [ADDR_WIDTH-1:0] row_base, row_nx, base, push_addr;
  logic [1:0]            scale_q, scale_nx, s;
  logic                  beat, keep, line_end, frame_end;
  logic                  push, pop, full, empty;

  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [PW:0]    count;

  // sof resyncs position to (0,0) and latches the scale for the frame
  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    row_nx   = row_base;
    scale_nx = scale_q;
    s        = scale_q;
    cur_x    = x;
    cur_y    = y;
    base     = row_base;
    beat     = 1'b0;
    unique case (1'b1)
      in_valid && in_sof: begin
        beat     = 1'b1;
        s        = ctrl_foreground_scale;
        scale_nx = ctrl_foreground_scale;
        cur_x    = '0;
        cur_y    = '0;
        base     = '0;
        state_nx = S_RUN;
      end
      in_valid && !in_sof && state == S_RUN:
        beat = 1'b1;
      default: ;
    endcase
    mask      = ~({PRECISION{1'b1}} << s);
    line_end  = cur_x == X_LAST;
    frame_end = line_end && cur_y == Y_LAST;
    keep      = beat && (cur_x & mask) == '0
                     && (cur_y & mask) == '0;
    push_addr = base + ADDR_WIDTH'(cur_x >> s);
    if (beat) begin
      x_nx   = line_end ? '0 : cur_x + 1'b1;
      y_nx   = cur_y;
      row_nx = base;
      if (line_end) begin
        y_nx = frame_end ? '0 : cur_y + 1'b1;
        if (frame_end) begin
          row_nx   = '0;
          state_nx = S_WAIT;
        end else if ((cur_y & mask) == '0) begin
          row_nx = base + ROW_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_WAIT;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
      scale_q    <= 2'b00;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      x          <= x_nx;
      y          <= y_nx;
      row_base   <= row_nx;
      scale_q    <= scale_nx;
      frame_done <= beat && frame_end;
      if (keep && !push) overflow <= 1'b1;
    end
  end

  assign empty = count == '0;
  assign full  = count == CNT_FULL;
  assign pop   = !empty && wr.wr_ready;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign push  = keep && (!full || pop);

  assign wr.wr_valid = !empty;
  assign {wr.wr_addr, wr.wr_data} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_addr, in_pixel};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
